// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM client arbiter.
// Imported by the interface, picker and top.
package sdram_arb_pkg;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int MASK_W = 2;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;
endpackage

// File: rtl/sdram_arbiter_n_if.sv
// Controller-side port bundle and per-channel client bundle.
// The arbiter is master of the controller port, slave of the clients.
interface sdram_port_if
  import sdram_arb_pkg::*;
;
  logic              sdram_cmd_valid;
  logic              sdram_cmd_ready;
  logic              sdram_wr;
  logic [ADDR_W-1:0] sdram_addr_x16;
  logic [DATA_W-1:0] sdram_wdata;
  logic [MASK_W-1:0] sdram_wmask;
  logic              sdram_burst;
  logic              sdram_ack;
  logic              sdram_rdy;
  logic              sdram_resp_valid;
  logic              sdram_resp_last;
  logic [DATA_W-1:0] sdram_rdata;

  modport master (
    output sdram_cmd_valid, sdram_wr,
    output sdram_addr_x16, sdram_wdata,
    output sdram_wmask, sdram_burst,
    output sdram_ack,
    input  sdram_cmd_ready, sdram_rdy,
    input  sdram_resp_valid,
    input  sdram_resp_last, sdram_rdata
  );

  modport slave (
    input  sdram_cmd_valid, sdram_wr,
    input  sdram_addr_x16, sdram_wdata,
    input  sdram_wmask, sdram_burst,
    input  sdram_ack,
    output sdram_cmd_ready, sdram_rdy,
    output sdram_resp_valid,
    output sdram_resp_last, sdram_rdata
  );
endinterface

interface sdram_ch_if
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]        ch_cmd_valid;
  logic [NUM_CH-1:0]        ch_cmd_ready;
  logic [NUM_CH-1:0]        ch_wr;
  logic [ADDR_W*NUM_CH-1:0] ch_addr_x16;
  logic [DATA_W*NUM_CH-1:0] ch_wdata;
  logic [MASK_W*NUM_CH-1:0] ch_wmask;
  logic [NUM_CH-1:0]        ch_ack;
  logic [NUM_CH-1:0]        ch_rdy;
  logic [NUM_CH-1:0]        ch_resp_valid;
  logic [NUM_CH-1:0]        ch_resp_last;
  logic [DATA_W-1:0]        ch_rdata;

  modport master (
    output ch_cmd_valid, ch_wr,
    output ch_addr_x16, ch_wdata,
    output ch_wmask, ch_ack,
    input  ch_cmd_ready, ch_rdy,
    input  ch_resp_valid, ch_resp_last,
    input  ch_rdata
  );

  modport slave (
    input  ch_cmd_valid, ch_wr,
    input  ch_addr_x16, ch_wdata,
    input  ch_wmask, ch_ack,
    output ch_cmd_ready, ch_rdy,
    output ch_resp_valid, ch_resp_last,
    output ch_rdata
  );
endinterface

// File: rtl/sdram_arbiter_n_pick.sv
// Request picker: fixed lowest-index or round-robin after ptr_i.
// Returns one-hot grant, its index and an any-request flag.
module arb_rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter bit RR_EN  = 1'b0,
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IW-1:0]     idx_o,
  output logic              any_o
);
  int c;

  // Walk lowest to highest priority; the last hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = |req_i;
    c     = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (RR_EN) c = (int'(ptr_i) + k) % NUM_CH;
      else       c = k - 1;
      if (req_i[c]) begin
        gnt_o    = '0;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end
endmodule

// File: rtl/sdram_arbiter_n.sv
// N-channel arbiter in front of a single-command SDRAM port.
// Locks to one owner from acceptance until that owner acks.
module sdram_arbiter_n
  import sdram_arb_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter bit          RR_EN      = 1'b0,
  parameter int          WAITSTATES = 2,
  parameter logic [NUM_CH-1:0] BURST_CH =
    NUM_CH'(4'b0010),
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  sdram_port_if.master      mem,
  sdram_ch_if.slave         ch,
  output logic [NUM_CH-1:0] grant_o
);
  arb_state_e        state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [IW-1:0]     own_q, own_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [NUM_CH-1:0] w_gnt, owner;
  logic [IW-1:0]     w_idx, sel;
  logic              any_req, busy, accept, rel;
  logic              fld_en, is_bst, rdy_ok;

  arb_rr_pick #(
    .NUM_CH(NUM_CH),
    .RR_EN (RR_EN)
  ) u_pick (
    .req_i(ch.ch_cmd_valid),
    .ptr_i(ptr_q),
    .gnt_o(w_gnt),
    .idx_o(w_idx),
    .any_o(any_req)
  );

  assign busy   = (state_q == ARB_BUSY);
  assign accept = !busy && any_req
                  && mem.sdram_cmd_ready;
  assign rel    = busy && ch.ch_ack[own_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      own_q   <= '0;
      ptr_q   <= IW'(NUM_CH - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          state_d = ARB_BUSY;
          grant_d = w_gnt;
          own_d   = w_idx;
          ptr_d   = w_idx;
          cnt_d   = 3'(WAITSTATES);
        end
      end
      ARB_BUSY: begin
        if (cnt_q != 3'd0)
          cnt_d = cnt_q - 3'd1;
        if (rel) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Command fields follow the winner when idle, the owner when busy.
  assign sel    = busy ? own_q : w_idx;
  assign fld_en = busy || any_req;
  assign is_bst = BURST_CH[sel];

  assign mem.sdram_cmd_valid =
    !rst_i && !busy && any_req;
  assign mem.sdram_wr =
    fld_en && !is_bst && ch.ch_wr[sel];
  assign mem.sdram_burst = fld_en && is_bst;
  assign mem.sdram_addr_x16 = fld_en ?
    ch.ch_addr_x16[sel*ADDR_W +: ADDR_W] : '0;
  assign mem.sdram_wdata = (fld_en && !is_bst) ?
    ch.ch_wdata[sel*DATA_W +: DATA_W] : '0;
  assign mem.sdram_wmask = (fld_en && !is_bst) ?
    ch.ch_wmask[sel*MASK_W +: MASK_W] : '0;
  assign mem.sdram_ack = !rst_i && rel;

  assign ch.ch_cmd_ready =
    (!rst_i && !busy && mem.sdram_cmd_ready) ?
    w_gnt : '0;

  assign owner  = rst_i ? '0 : grant_q;
  assign rdy_ok = mem.sdram_rdy && (cnt_q == 3'd0);

  assign ch.ch_rdy =
    owner & {NUM_CH{rdy_ok}};
  assign ch.ch_resp_valid =
    owner & {NUM_CH{mem.sdram_resp_valid}};
  assign ch.ch_resp_last =
    owner & {NUM_CH{mem.sdram_resp_last}};
  assign ch.ch_rdata = mem.sdram_rdata;
  assign grant_o     = owner;
endmodule

// File: tb/tb_sdram_arbiter_n.sv
// Directed bench: fixed-priority instance and round-robin instance.
// Expected values are hand-computed constants.
module tb_sdram_arbiter_n;
  logic clk = 1'b0;
  logic rst_i;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sdram_port_if           pf ();
  sdram_ch_if #(.NUM_CH(4)) cf ();
  sdram_port_if           pr ();
  sdram_ch_if #(.NUM_CH(4)) cr ();
  logic [3:0] gf, gr;

  sdram_arbiter_n #(
    .NUM_CH(4), .RR_EN(1'b0),
    .WAITSTATES(2), .BURST_CH(4'b0010)
  ) dut_f (
    .clk_i(clk), .rst_i(rst_i),
    .mem(pf), .ch(cf), .grant_o(gf)
  );

  sdram_arbiter_n #(
    .NUM_CH(4), .RR_EN(1'b1),
    .WAITSTATES(2), .BURST_CH(4'b0010)
  ) dut_r (
    .clk_i(clk), .rst_i(rst_i),
    .mem(pr), .ch(cr), .grant_o(gr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b0100,
               4'b1000, 4'b0001};
    rst_i = 1'b1;
    pf.sdram_cmd_ready  = 1'b1;
    pf.sdram_rdy        = 1'b0;
    pf.sdram_resp_valid = 1'b0;
    pf.sdram_resp_last  = 1'b0;
    pf.sdram_rdata      = 16'h0;
    cf.ch_cmd_valid = 4'b1111;
    cf.ch_wr        = 4'b1111;
    cf.ch_ack       = 4'b0000;
    cf.ch_addr_x16  = {24'h033330, 24'h022220,
                       24'h012340, 24'h000100};
    cf.ch_wdata     = {16'hD333, 16'hC222,
                       16'hB111, 16'hA000};
    cf.ch_wmask     = {2'b11, 2'b10,
                       2'b01, 2'b11};
    pr.sdram_cmd_ready  = 1'b0;
    pr.sdram_rdy        = 1'b0;
    pr.sdram_resp_valid = 1'b0;
    pr.sdram_resp_last  = 1'b0;
    pr.sdram_rdata      = 16'h0;
    cr.ch_cmd_valid = 4'b0000;
    cr.ch_wr        = 4'b0000;
    cr.ch_ack       = 4'b0000;
    cr.ch_addr_x16  = '0;
    cr.ch_wdata     = '0;
    cr.ch_wmask     = '0;

    // reset with every channel requesting
    for (int i = 0; i < 3; i++) begin
      smp;
      chk("rst_ready", 32'(cf.ch_cmd_ready), 0);
      chk("rst_grant", 32'(gf), 0);
      chk("rst_cvalid", 32'(pf.sdram_cmd_valid), 0);
      nxt;
    end
    rst_i = 1'b0;

    // first grant after reset goes to ch0
    smp;
    chk("a_ready", 32'(cf.ch_cmd_ready), 4'b0001);
    chk("a_cvalid", 32'(pf.sdram_cmd_valid), 1);
    chk("a_addr", 32'(pf.sdram_addr_x16), 24'h000100);
    chk("a_wr", 32'(pf.sdram_wr), 1);
    chk("a_burst", 32'(pf.sdram_burst), 0);
    chk("a_wdata", 32'(pf.sdram_wdata), 16'hA000);
    chk("a_grant_idle", 32'(gf), 0);
    nxt;

    cf.ch_ack = 4'b0001;
    cf.ch_cmd_valid = 4'b1110;
    smp;
    chk("b_grant", 32'(gf), 4'b0001);
    chk("b_cvalid", 32'(pf.sdram_cmd_valid), 0);
    chk("b_ready", 32'(cf.ch_cmd_ready), 0);
    chk("b_ack", 32'(pf.sdram_ack), 1);
    nxt;

    // ch1 (burst) beats ch3; rdy held high from acceptance
    cf.ch_ack = 4'b0000;
    cf.ch_cmd_valid = 4'b1010;
    pf.sdram_rdy = 1'b1;
    smp;
    chk("c_ready", 32'(cf.ch_cmd_ready), 4'b0010);
    chk("c_addr", 32'(pf.sdram_addr_x16), 24'h012340);
    chk("c_burst", 32'(pf.sdram_burst), 1);
    chk("c_wr", 32'(pf.sdram_wr), 0);
    chk("c_grant", 32'(gf), 0);
    nxt;

    smp;
    chk("d1_grant", 32'(gf), 4'b0010);
    chk("d1_rdy", 32'(cf.ch_rdy), 0);
    nxt;
    smp;
    chk("d2_rdy", 32'(cf.ch_rdy), 0);
    nxt;
    pf.sdram_resp_valid = 1'b1;
    pf.sdram_resp_last  = 1'b1;
    pf.sdram_rdata      = 16'hBEEF;
    smp;
    chk("d3_rdy", 32'(cf.ch_rdy), 4'b0010);
    chk("d3_rvalid", 32'(cf.ch_resp_valid), 4'b0010);
    chk("d3_rlast", 32'(cf.ch_resp_last), 4'b0010);
    chk("d3_rdata", 32'(cf.ch_rdata), 16'hBEEF);
    chk("d3_addr", 32'(pf.sdram_addr_x16), 24'h012340);
    nxt;

    // reset in the middle of the burst
    rst_i = 1'b1;
    smp;
    chk("e_grant", 32'(gf), 0);
    chk("e_rvalid", 32'(cf.ch_resp_valid), 0);
    chk("e_rdy", 32'(cf.ch_rdy), 0);
    chk("e_ready", 32'(cf.ch_cmd_ready), 0);
    nxt;

    rst_i = 1'b0;
    pf.sdram_rdy        = 1'b0;
    pf.sdram_resp_valid = 1'b0;
    pf.sdram_resp_last  = 1'b0;
    smp;
    chk("f_grant", 32'(gf), 0);
    chk("f_ready", 32'(cf.ch_cmd_ready), 4'b0010);
    nxt;

    cf.ch_ack = 4'b0010;
    cf.ch_cmd_valid = 4'b1000;
    smp;
    chk("g_ack", 32'(pf.sdram_ack), 1);
    nxt;

    // ch3 granted on the first idle cycle
    cf.ch_ack = 4'b0000;
    smp;
    chk("h_ready", 32'(cf.ch_cmd_ready), 4'b1000);
    chk("h_addr", 32'(pf.sdram_addr_x16), 24'h033330);
    chk("h_wr", 32'(pf.sdram_wr), 1);
    chk("h_burst", 32'(pf.sdram_burst), 0);
    chk("h_wdata", 32'(pf.sdram_wdata), 16'hD333);
    chk("h_wmask", 32'(pf.sdram_wmask), 2'b11);
    nxt;

    cf.ch_ack = 4'b1000;
    cf.ch_cmd_valid = 4'b0000;
    nxt;

    // idle, no request; ch_wr still high
    cf.ch_ack = 4'b0000;
    smp;
    chk("j_cvalid", 32'(pf.sdram_cmd_valid), 0);
    chk("j_addr", 32'(pf.sdram_addr_x16), 0);
    chk("j_burst", 32'(pf.sdram_burst), 0);
    chk("j_ack", 32'(pf.sdram_ack), 0);
    chk("j_ready", 32'(cf.ch_cmd_ready), 0);
    nxt;
    smp;
    chk("j_grant", 32'(gf), 0);
    nxt;

    // controller not ready: no acceptance
    cf.ch_cmd_valid = 4'b0001;
    pf.sdram_cmd_ready = 1'b0;
    smp;
    chk("k_cvalid", 32'(pf.sdram_cmd_valid), 1);
    chk("k_ready", 32'(cf.ch_cmd_ready), 0);
    nxt;
    smp;
    chk("k_grant", 32'(gf), 0);
    nxt;

    pf.sdram_cmd_ready = 1'b1;
    cf.ch_cmd_valid = 4'b0100;
    smp;
    chk("k_ready2", 32'(cf.ch_cmd_ready), 4'b0100);
    nxt;

    // foreign ack must be ignored
    cf.ch_cmd_valid = 4'b0000;
    cf.ch_ack = 4'b0001;
    smp;
    chk("l_ack0", 32'(pf.sdram_ack), 0);
    chk("l_grant0", 32'(gf), 4'b0100);
    nxt;
    cf.ch_ack = 4'b0100;
    smp;
    chk("l_grant1", 32'(gf), 4'b0100);
    chk("l_ack2", 32'(pf.sdram_ack), 1);
    nxt;
    cf.ch_ack = 4'b0000;
    smp;
    chk("l_grant2", 32'(gf), 0);
    nxt;

    // round-robin with all four requesting
    pr.sdram_cmd_ready = 1'b1;
    cr.ch_cmd_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      smp;
      chk("rr_ready", 32'(cr.ch_cmd_ready),
          32'(rr_exp[k]));
      nxt;
      smp;
      chk("rr_grant", 32'(gr), 32'(rr_exp[k]));
      nxt;
      nxt;
      nxt;
      cr.ch_ack = rr_exp[k];
      smp;
      chk("rr_ack", 32'(pr.sdram_ack), 1);
      nxt;
      cr.ch_ack = 4'b0000;
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter_n.md
Name: sdram_arbiter_n

Overview:
N-channel arbiter between SDRAM clients (CPU, video, blitter, audio DMA...) and the single-command SDRAM controller port. Forwards one command at a time in the same cycle it is requested, locks the mux to that channel until the channel acks, and routes rdy/response strobes back to the owner only. Supersedes the fixed two-client CPU/video arbiter with parametrised channel count, selectable fixed-priority or round-robin arbitration, per-channel burst mode and a configurable rdy-masking wait-state count.

Parameters:
NUM_CH, 4, number of client channels (2..8); channel 0 is highest priority in fixed mode
RR_EN, 0, 0 = fixed priority (lowest index wins), 1 = round-robin starting after last granted channel
WAITSTATES, 2, cycles after acceptance during which sdram_rdy is masked from the owner (0..7)
BURST_CH, 4'b0010, bit i = 1: channel i is read-only burst (sdram_burst=1, sdram_wr=0, wdata/wmask ignored)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active high
sdram_cmd_valid  out  1  command to controller
sdram_cmd_ready  in  1  controller can accept
sdram_wr  out  1  write
sdram_addr_x16  out  24  halfword address
sdram_wdata  out  16  write data
sdram_wmask  out  2  byte enables
sdram_burst  out  1  burst read
sdram_ack  out  1  owner ack forwarded
sdram_rdy  in  1  controller done/data ready
sdram_resp_valid  in  1  read beat valid
sdram_resp_last  in  1  last beat
sdram_rdata  in  16  read data
ch_cmd_valid  in  NUM_CH  per-channel request
ch_cmd_ready  out  NUM_CH  per-channel accept (combinational)
ch_wr  in  NUM_CH  per-channel write
ch_addr_x16  in  24*NUM_CH  packed addresses, channel i at [24*i +: 24]
ch_wdata  in  16*NUM_CH  packed write data
ch_wmask  in  2*NUM_CH  packed byte enables
ch_ack  in  NUM_CH  owner releases bus
ch_rdy  out  NUM_CH  gated sdram_rdy
ch_resp_valid  out  NUM_CH  gated sdram_resp_valid
ch_resp_last  out  NUM_CH  gated sdram_resp_last
ch_rdata  out  16  shared read data (= sdram_rdata, ungated)
grant_o  out  NUM_CH  one-hot current owner, 0 when idle (debug/perf counters)

Behaviour:
- States: IDLE, BUSY. Reset (any cycle, including mid-transaction): state=IDLE, grant=0, waitstate counter=0, RR pointer=NUM_CH-1 (so channel 0 is first candidate). Outputs during/after reset: all ch_cmd_ready=0, ch_rdy=0, ch_resp_valid=0, ch_resp_last=0, sdram_cmd_valid=0, sdram_ack=0, grant_o=0.
- IDLE: winner w = arbitration over ch_cmd_valid (fixed: lowest index; RR: first valid index after pointer, wrapping modulo NUM_CH). sdram_cmd_valid = |ch_cmd_valid. sdram_wr/addr/wdata/wmask/burst driven from w combinationally. ch_cmd_ready[w] = !rst_i && sdram_cmd_ready; all others 0.
- Acceptance (IDLE && sdram_cmd_ready && any valid): next cycle BUSY, grant=onehot(w), counter=WAITSTATES, RR pointer=w. No acceptance without ch_cmd_valid (a stray ch_wr never grants).
- BUSY: sdram_cmd_valid=0, all ch_cmd_ready=0; command fields held from owner. ch_rdy[owner]=sdram_rdy && counter==0; ch_resp_valid/last[owner] follow sdram inputs; non-owners 0. sdram_ack=ch_ack[owner]; other channels' acks ignored. Counter decrements to 0 and saturates.
- Release: BUSY && ch_ack[owner] -> IDLE next cycle; earliest next acceptance is that following cycle (one idle bubble minimum between transactions).
- IDLE with no valid: sdram_ack=0, command fields 0, burst=0.
- Burst channels: sdram_wr forced 0, sdram_burst=1 regardless of ch_wr.
- Simultaneous valid from several channels: exactly one ready asserted per cycle.

Decomposition:
- Package sdram_arb_pkg: state enum (ARB_IDLE, ARB_BUSY), ADDR_W=24, DATA_W=16, MASK_W=2 constants.
- Sub-module arb_rr_pick (NUM_CH, RR_EN): combinational picker from request vector + pointer to one-hot and index; reused by future DMA arbiters.

Test Plan:
- Reset: assert rst_i for 3 cycles with ch_cmd_valid=4'b1111, sdram_cmd_ready=1 -> ch_cmd_ready=0, grant_o=0, no acceptance; first grant in cycle after deassert goes to ch0.
- Fixed priority: RR_EN=0, ch_cmd_valid=4'b1010 -> ch1 granted, sdram_addr_x16=ch1 addr (e.g. 24'h012340), sdram_burst=1, sdram_wr=0; after ch_ack[1] and ch1 dropping valid, ch3 granted next idle cycle.
- Round-robin: RR_EN=1, all four valid continuously, each acking after 4 cycles -> grant order 0,1,2,3,0.
- Wait-state masking: WAITSTATES=2, sdram_rdy=1 from acceptance -> ch_rdy[owner]=0 for 2 BUSY cycles, 1 on third; non-owner ch_rdy stays 0.
- Ack isolation: owner ch2 BUSY, pulse ch_ack[0] -> state stays BUSY, sdram_ack=0; pulse ch_ack[2] -> IDLE next cycle.
- Reset mid-burst: ch1 BUSY with resp_valid beats flowing, rst_i 1 cycle -> grant_o=0, ch_resp_valid=0 same cycle, IDLE afterwards.
